mandelbrot_scan_scheduler: RTL

Frame-level sequencer for the mandelbrot engine. Walks a raster of H_PIXELS x V_PIXELS points and derives each point's complex coordinate incrementally from an origin and a step. For each pixel it issues one engine job, captures the iteration count and hands it to the framebuffer write port over a valid/ready handshake. Sits between the configuration shift register / RP2040 control pins and the engine + framebuffer.

---
 rtl/mandelbrot_pkg.sv | 20 ++
 rtl/mandelbrot_coord_stepper.sv | 88 ++++++++
 rtl/mandelbrot_scan_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mandelbrot_pkg : shared state encoding and default datapath widths    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mandelbrot_pkg;

  localparam int BITWIDTH_DEF = 11;
  localparam int CTRWIDTH_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mandelbrot_coord_stepper.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mandelbrot_coord_stepper : raster x/y counters and cr/ci accumulators |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mandelbrot_coord_stepper
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120,
  localparam int XW = $clog2(H_PIXELS),
  localparam int YW = $clog2(V_PIXELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                step_x_i,
  input  logic                step_y_i,
  input  logic [BITWIDTH-1:0] cr_origin_i,
  input  logic [BITWIDTH-1:0] ci_origin_i,
  input  logic [BITWIDTH-1:0] step_i,
  output logic [BITWIDTH-1:0] cr_o,
  output logic [BITWIDTH-1:0] ci_o,
  output logic                x_last_o,
  output logic                y_last_o,
  output logic                first_o
);

  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [BITWIDTH-1:0] cr_q, cr_d;
  logic [BITWIDTH-1:0] ci_q, ci_d;
  logic [BITWIDTH-1:0] cr_org_q, cr_org_d;
  logic [BITWIDTH-1:0] step_q, step_d;

  // Coordinates wrap modulo 2^BITWIDTH; rows advance downward, so ci decreases.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    cr_d     = cr_q;
    ci_d     = ci_q;
    cr_org_d = cr_org_q;
    step_d   = step_q;
    if (load_i) begin
      x_d      = '0;
      y_d      = '0;
      cr_d     = cr_origin_i;
      ci_d     = ci_origin_i;
      cr_org_d = cr_origin_i;
      step_d   = step_i;
    end else if (step_x_i) begin
      x_d  = x_q + XW'(1);
      cr_d = cr_q + step_q;
    end else if (step_y_i) begin
      x_d  = '0;
      y_d  = y_q + YW'(1);
      cr_d = cr_org_q;
      ci_d = ci_q - step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      cr_q     <= '0;
      ci_q     <= '0;
      cr_org_q <= '0;
      step_q   <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      cr_q     <= cr_d;
      ci_q     <= ci_d;
      cr_org_q <= cr_org_d;
      step_q   <= step_d;
    end
  end

  assign cr_o     = cr_q;
  assign ci_o     = ci_q;
  assign x_last_o = (x_q == XW'(H_PIXELS - 1));
  assign y_last_o = (y_q == YW'(V_PIXELS - 1));
  assign first_o  = (x_q == '0) && (y_q == '0);

endmodule
`default_nettype wire

// File: rtl/mandelbrot_scan_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mandelbrot_scan_scheduler : per-pixel engine job / framebuffer writer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mandelbrot_scan_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int CTRWIDTH = CTRWIDTH_DEF,
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BITWIDTH-1:0] cr_origin_i,
  input  logic [BITWIDTH-1:0] ci_origin_i,
  input  logic [BITWIDTH-1:0] step_i,
  output logic                eng_start_o,
  output logic [BITWIDTH-1:0] eng_cr_o,
  output logic [BITWIDTH-1:0] eng_ci_o,
  input  logic                eng_done_i,
  input  logic [CTRWIDTH-1:0] eng_iter_i,
  output logic                wr_valid_o,
  output logic [CTRWIDTH-1:0] wr_data_o,
  output logic                wr_sof_o,
  input  logic                wr_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  state_e              state_q, state_d;
  logic [CTRWIDTH-1:0] wr_data_q, wr_data_d;
  logic                load, step_x, step_y, capture;
  logic                x_last, y_last, first;

  mandelbrot_coord_stepper #(
    .BITWIDTH (BITWIDTH),
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS)
  ) u_stepper (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_x_i    (step_x),
    .step_y_i    (step_y),
    .cr_origin_i (cr_origin_i),
    .ci_origin_i (ci_origin_i),
    .step_i      (step_i),
    .cr_o        (eng_cr_o),
    .ci_o        (eng_ci_o),
    .x_last_o    (x_last),
    .y_last_o    (y_last),
    .first_o     (first)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i)    state_d = ST_LAUNCH;
      ST_LAUNCH:                        state_d = ST_WAIT;
      ST_WAIT:          if (eng_done_i) state_d = ST_EMIT;
      ST_EMIT:          if (wr_ready_i) state_d = (x_last && y_last) ? ST_DONE : ST_LAUNCH;
      default:                          state_d = ST_IDLE;
    endcase
    // An abandoned job's late eng_done is harmless: it only matters in WAIT.
    if (abort_i) state_d = ST_IDLE;
  end

  always_comb begin
    eng_start_o = (state_q == ST_LAUNCH);
    wr_valid_o  = (state_q == ST_EMIT);
    wr_sof_o    = (state_q == ST_EMIT) && first;
    busy_o      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_EMIT);
    done_o      = (state_q == ST_DONE);
    load        = !abort_i && start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    capture     = !abort_i && eng_done_i && (state_q == ST_WAIT);
    step_x      = !abort_i && wr_ready_i && (state_q == ST_EMIT) && !x_last;
    step_y      = !abort_i && wr_ready_i && (state_q == ST_EMIT) && x_last && !y_last;
    wr_data_d   = capture ? eng_iter_i : wr_data_q;
  end

  assign wr_data_o = wr_data_q;

endmodule
`default_nettype wire
